// File: rtl/sample_arb_pkg.sv
// Shared types and constants for the sample ROM arbiter.
package sample_arb_pkg;

   localparam int SAMPLE_ADDR_W    = 14;
   localparam int SAMPLE_DATA_W    = 16;
   localparam int SAMPLE_ROM_DEPTH = 8770;

   // One tag-pipe stage: read in flight and which requester it belongs to.
   typedef struct packed {
      logic       vld;
      logic [2:0] idx;
   } arb_tag_t;

   // Binary requester index to one-hot strobe (up to 8 requesters).
   function automatic logic [7:0] onehot(input logic [2:0] idx);
      onehot = 8'b0000_0001 << idx;
   endfunction

endpackage

// File: rtl/sample_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests so the pointer
// position becomes bit 0, take the lowest set bit, rotate back.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] pos [N_REQ];
   logic [N_REQ-1:0] rot;
   logic [N_REQ-1:0] pick;

   // Rotated position i maps to requester (i + ptr) mod N_REQ.
   always_comb begin
      int s;
      s = 0;
      for (int i = 0; i < N_REQ; i++) begin
         s = i + int'(ptr);
         if (s >= N_REQ) s = s - N_REQ;
         pos[i] = IDX_W'(s);
      end
   end

   // Rotate, isolate lowest set bit.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) rot[i] = req[pos[i]];
      pick = rot & (~rot + N_REQ'(1));
   end

   // Rotate the winner back to requester numbering.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick[i]) begin
            gnt[pos[i]] = 1'b1;
            idx         = pos[i];
         end
      end
   end

endmodule

// File: rtl/sample_rom_arbiter.sv
// Sample ROM arbiter: shares one single-port sample ROM among N_REQ voice
// players with round-robin grants, carrying the requester tag through the
// ROM latency and returning data with a per-requester valid strobe.
// Optional build macro SAMPLE_ARB_PRIO0_EN: requester 0 (drum pad) takes
// absolute priority; the others round-robin over pointer range 1..N_REQ-1.
module sample_rom_arbiter
   import sample_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = SAMPLE_ADDR_W,
   parameter int DATA_W  = SAMPLE_DATA_W,
   parameter int ROM_LAT = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic                    flush,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        rd_valid,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    busy,
   output logic                    rom_en,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_dout
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  ptr_next;
   logic [N_REQ-1:0]  req_rr;
   logic [N_REQ-1:0]  pick_gnt;
   logic [IDX_W-1:0]  pick_idx;
   logic [N_REQ-1:0]  gnt_raw;
   logic [IDX_W-1:0]  gnt_idx;
   logic              prio_hit;
   logic              gnt_any;
   logic              issue;
   logic [ADDR_W-1:0] sel_addr;
   arb_tag_t          tag_pipe [ROM_LAT+1];

`ifdef SAMPLE_ARB_PRIO0_EN
   // Requester 0 bypasses the rotation; the pointer never visits 0.
   localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(1);
   assign req_rr   = req & ~N_REQ'(1);
   assign prio_hit = req[0];
`else
   localparam logic [IDX_W-1:0] PTR_RST = '0;
   assign req_rr   = req;
   assign prio_hit = 1'b0;
`endif

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req (req_rr),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   // Final grant selection, suppressed while reset is asserted.
   always_comb begin
      gnt_raw  = prio_hit ? N_REQ'(1) : pick_gnt;
      gnt_idx  = prio_hit ? '0 : pick_idx;
      ptr_next = (pick_idx == IDX_LAST) ? PTR_RST : pick_idx + IDX_W'(1);
   end

   assign gnt     = reset ? gnt_raw : '0;
   assign gnt_any = |gnt;
   // A grant in a flush cycle is discarded, so it never reaches the ROM.
   assign issue   = gnt_any & ~flush;

   // Address of the granted requester.
   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_raw[i]) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
   end

   // Round-robin pointer: advance past the winner, including in flush cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= PTR_RST;
      end else if (gnt_any && !prio_hit) begin
         rr_ptr <= ptr_next;
      end
   end

   // ROM enable/address registers; address holds on idle cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rom_en   <= 1'b0;
         rom_addr <= '0;
      end else begin
         rom_en <= issue;
         if (issue) rom_addr <= sel_addr;
      end
   end

   // Tag shift pipe aligned with the ROM read; flush kills every stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k <= ROM_LAT; k++) tag_pipe[k] <= '0;
      end else begin
         tag_pipe[0].vld <= issue;
         tag_pipe[0].idx <= 3'(gnt_idx);
         for (int k = 1; k <= ROM_LAT; k++) begin
            tag_pipe[k].vld <= tag_pipe[k-1].vld & ~flush;
            tag_pipe[k].idx <= tag_pipe[k-1].idx;
         end
      end
   end

   // Output registers: capture ROM data with the owning requester's strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid <= '0;
         rd_data  <= '0;
      end else if (tag_pipe[ROM_LAT-1].vld && !flush) begin
         rd_valid <= N_REQ'(onehot(tag_pipe[ROM_LAT-1].idx));
         rd_data  <= rom_dout;
      end else begin
         rd_valid <= '0;
      end
   end

   // Busy while any tag stage holds a live read.
   always_comb begin
      busy = 1'b0;
      for (int k = 0; k <= ROM_LAT; k++) busy = busy | tag_pipe[k].vld;
   end

endmodule

// File: tb/tb_sample_rom_arbiter.sv
// Testbench for sample_rom_arbiter (default parameters).
module tb_sample_rom_arbiter;

   localparam int N  = 4;
   localparam int AW = 14;
   localparam int DW = 16;
`ifdef SAMPLE_ARB_PRIO0_EN
   localparam int PTR_RST = 1;
   localparam bit PRIO    = 1'b1;
`else
   localparam int PTR_RST = 0;
   localparam bit PRIO    = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic            flush;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rd_valid;
   logic [DW-1:0]   rd_data;
   logic            busy;
   logic            rom_en;
   logic [AW-1:0]   rom_addr;
   logic [DW-1:0]   rom_dout;

   typedef struct {
      int            due;
      logic [N-1:0]  oh;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;
   int            mptr     = PTR_RST;
   logic          exp_en   = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] last_data = '0;

   sample_rom_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_addr (req_addr),
      .flush    (flush),
      .gnt      (gnt),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .busy     (busy),
      .rom_en   (rom_en),
      .rom_addr (rom_addr),
      .rom_dout (rom_dout)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
      return (a == 14'h0123) ? 16'hBEEF : ({2'b11, a} ^ 16'h3C5A);
   endfunction

   assign rom_dout = rom_word(rom_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs were set just after a falling edge.
   task automatic step();
      int            g;
      exp_t          e;
      logic [N-1:0]  exp_gnt;
      logic [AW-1:0] a;
      #1;
      g = -1;
      if (reset) begin
         if (PRIO && req[0]) g = 0;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (mptr + k) % N;
            if (g < 0 && req[c]) g = c;
         end
      end
      exp_gnt = (g >= 0) ? N'(1 << g) : '0;
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      if (!reset) begin
         sb.delete();
         mptr      = PTR_RST;
         exp_en    = 1'b0;
         exp_addr  = '0;
         last_data = '0;
      end
      chk("busy", 32'(busy), 32'(sb.size() > 0));
      chk("rom_en", 32'(rom_en), 32'(exp_en));
      chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk("rd_valid", 32'(rd_valid), 32'(e.oh));
         chk("rd_data", 32'(rd_data), 32'(e.data));
         last_data = e.data;
      end else begin
         chk("rd_valid_idle", 32'(rd_valid), 32'(0));
         chk("rd_data_hold", 32'(rd_data), 32'(last_data));
      end
      exp_en = (g >= 0) && !flush;
      if (flush) sb.delete();
      if (exp_en) begin
         a        = req_addr[g*AW +: AW];
         exp_addr = a;
         sb.push_back('{cyc + 2, exp_gnt, rom_word(a)});
      end
      if (g >= 0 && !(PRIO && g == 0)) begin
         mptr = (g + 1) % N;
         if (PRIO && mptr == 0) mptr = 1;
      end
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      reset    = 1'b0;
      flush    = 1'b0;
      req      = 4'b1111;
      req_addr = '0;
      @(negedge clk);
      // Reset held with all requests up.
      step();
      step();
      reset = 1'b1;
      step();
      req = '0;
      repeat (3) step();

      // Single read of the known ROM word.
      req = 4'b0100;
      req_addr[2*AW +: AW] = 14'h0123;
      step();
      req = '0;
      repeat (3) step();

      // Park the pointer at 0, then all four requesting for 8 cycles.
      req = 4'b1000;
      step();
      for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(14'h1000 + 14'(i * 16'h111));
      req = 4'b1111;
      repeat (8) step();
      req = '0;
      repeat (3) step();

      // Back-to-back grants with flush in the second cycle.
      req = 4'b0011;
      step();
      flush = 1'b1;
      req   = 4'b0010;
      step();
      flush = 1'b0;
      req   = 4'b0100;
      step();
      req = '0;
      repeat (3) step();

      // Reset pulse right after a grant.
      req = 4'b0010;
      step();
      reset = 1'b0;
      req   = '0;
      step();
      reset = 1'b1;
      step();
      req = 4'b1111;
      step();
      req = '0;
      repeat (3) step();

`ifdef SAMPLE_ARB_PRIO0_EN
      req = 4'b1011;
      repeat (4) step();
      req = 4'b1010;
      repeat (4) step();
      req = '0;
      repeat (3) step();
`endif

      // Random traffic with occasional flush.
      repeat (40) begin
         req      = N'($urandom_range(0, 15));
         req_addr = 56'({$urandom(), $urandom()});
         flush    = ($urandom_range(0, 7) == 0);
         step();
      end
      flush = 1'b0;
      req   = '0;
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
